// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: icode values, memory-stage FSM states and word size.
// Also the per-icode access decode shared by the memory stage.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam int WORD_BYTES = 8;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [63:0] addr;
    logic [63:0] wdata;
  } mem_req_t;

  function automatic mem_req_t decode_access(input logic [3:0] icode,
                                             input logic [63:0] val_a,
                                             input logic [63:0] val_e,
                                             input logic [63:0] val_p);
    mem_req_t req;
    req = '{rd: 1'b0, wr: 1'b0, addr: 64'd0, wdata: 64'd0};
    case (icode)
      I_RMMOVQ, I_PUSHQ: req = '{rd: 1'b0, wr: 1'b1, addr: val_e, wdata: val_a};
      I_CALL:            req = '{rd: 1'b0, wr: 1'b1, addr: val_e, wdata: val_p};
      I_MRMOVQ:          req = '{rd: 1'b1, wr: 1'b0, addr: val_e, wdata: 64'd0};
      I_RET, I_POPQ:     req = '{rd: 1'b1, wr: 1'b0, addr: val_a, wdata: 64'd0};
      default:           req = '{rd: 1'b0, wr: 1'b0, addr: 64'd0, wdata: 64'd0};
    endcase
    return req;
  endfunction

endpackage

// File: rtl/memory_ins_if.sv
// Start/done handshake and data bus between the SEQ datapath and the memory stage.
interface memory_ins_if;
  logic        start;
  logic [3:0]  icode;
  logic [63:0] valA;
  logic [63:0] valE;
  logic [63:0] valP;
  logic        busy;
  logic        done;
  logic [63:0] valM;
  logic        dmem_error;

  modport master (output start, icode, valA, valE, valP,
                  input  busy, done, valM, dmem_error);
  modport slave  (input  start, icode, valA, valE, valP,
                  output busy, done, valM, dmem_error);
endinterface

// File: rtl/dmem_bytes.sv
// Single-port DEPTH x 8 data memory: synchronous write, combinational read.
// Because read data is combinational, memory_ins needs no extra pipeline beat.
module dmem_bytes #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        wdata,
  output logic [7:0]        rdata
);
  logic [7:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) r_mem[addr] <= wdata;
  end

  assign rdata = r_mem[addr];
endmodule

// File: rtl/memory_ins.sv
// Y86-64 SEQ memory stage: 8-byte little-endian load/store, one byte per cycle,
// with range check and start/done handshake.
module memory_ins
  import y86_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input logic        clk,
  input logic        rst,
  memory_ins_if.slave bus
);
  mem_req_t          w_req;
  logic              w_err;
  logic              w_we;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [7:0]        w_rdata;
  logic [63:0]       w_asm_next;

  state_t            r_state;
  logic              r_busy;
  logic              r_done;
  logic              r_err;
  logic [63:0]       r_valM;
  logic [2:0]        r_beat;
  logic              r_is_wr;
  logic [ADDR_W-1:0] r_addr;
  logic [63:0]       r_wdata;
  logic [63:0]       r_asm;

  always_comb begin
    w_req = decode_access(bus.icode, bus.valA, bus.valE, bus.valP);
    // 65-bit compare so addresses near 2^64 cannot wrap into range
    w_err = (w_req.rd | w_req.wr) &&
            ({1'b0, w_req.addr} > 65'(DEPTH - WORD_BYTES));
  end

  assign w_we       = (r_state == ACCESS) && r_is_wr;
  assign w_mem_addr = r_addr + ADDR_W'(r_beat);
  // Bytes enter at the top and shift down, so after 8 beats byte k sits at bits 8k+7:8k
  assign w_asm_next = {w_rdata, r_asm[63:8]};

  dmem_bytes #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_mem (
    .clk   (clk),
    .we    (w_we),
    .addr  (w_mem_addr),
    .wdata (r_wdata[7:0]),
    .rdata (w_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_valM  <= 64'd0;
      r_beat  <= 3'd0;
      r_is_wr <= 1'b0;
      r_addr  <= '0;
      r_wdata <= 64'd0;
      r_asm   <= 64'd0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_busy  <= 1'b1;
            r_err   <= w_err;
            r_beat  <= 3'd0;
            r_is_wr <= w_req.wr;
            r_addr  <= w_req.addr[ADDR_W-1:0];
            r_wdata <= w_req.wdata;
            if ((w_req.rd | w_req.wr) && !w_err) begin
              r_state <= ACCESS;
            end else begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end
          end
        end
        ACCESS: begin
          r_beat  <= r_beat + 3'd1;
          r_wdata <= r_wdata >> 8;
          r_asm   <= w_asm_next;
          if (r_beat == 3'd7) begin
            r_state <= DONE;
            r_done  <= 1'b1;
            if (!r_is_wr) r_valM <= w_asm_next;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.valM       = r_valM;
  assign bus.dmem_error = r_err;
endmodule

// File: tb/tb_memory_ins.sv
// Directed bench for memory_ins: round trips, stack ops, range errors,
// no-op latency, start handshake and reset during a store.
module tb_memory_ins;
  import y86_pkg::*;

  // dmem_bytes reads combinationally: 8 ACCESS beats + 1 DONE cycle
  localparam int MEM_LAT = 9;
  localparam int NOP_LAT = 1;
  localparam int TMO     = 40;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  memory_ins_if bus();

  memory_ins #(.DEPTH(1024), .ADDR_W(10)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issue one request; returns cycles to done and valM/error seen while done=1.
  // With hold=1, start stays high and valA is corrupted until done.
  task automatic op(input logic [3:0] ic, input logic [63:0] a, input logic [63:0] e,
                    input logic [63:0] p, input bit hold,
                    output int lat, output logic [63:0] vm, output logic er);
    @(negedge clk);
    bus.icode = ic; bus.valA = a; bus.valE = e; bus.valP = p; bus.start = 1'b1;
    @(posedge clk); #1;
    if (hold) bus.valA = ~a; else bus.start = 1'b0;
    lat = 1;
    while (!bus.done && lat < TMO) begin
      @(posedge clk); #1;
      lat++;
    end
    vm = bus.valM; er = bus.dmem_error;
    bus.start = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    int          lat;
    logic [63:0] vm;
    logic        er;

    bus.start = 1'b0; bus.icode = 4'h0;
    bus.valA = 64'd0; bus.valE = 64'd0; bus.valP = 64'd0;
    #23;
    chk("rst_busy", {63'd0, bus.busy}, 64'd0);
    chk("rst_done", {63'd0, bus.done}, 64'd0);
    chk("rst_valM", bus.valM, 64'd0);
    chk("rst_err",  {63'd0, bus.dmem_error}, 64'd0);
    @(negedge clk); rst = 1'b0;

    // store / load round trip
    op(I_RMMOVQ, 64'h1122334455667788, 64'h10, 64'h0, 1'b0, lat, vm, er);
    chk("st_lat", 64'(lat), 64'(MEM_LAT));
    chk("st_err", {63'd0, er}, 64'd0);
    op(I_MRMOVQ, 64'h0, 64'h10, 64'h0, 1'b0, lat, vm, er);
    chk("ld_lat", 64'(lat), 64'(MEM_LAT));
    chk("ld_valM", vm, 64'h1122334455667788);
    op(I_MRMOVQ, 64'h0, 64'h17, 64'h0, 1'b0, lat, vm, er);
    chk("ld_b17", {56'd0, vm[7:0]}, 64'h11);

    // stack ops: push/pop and call/ret use different address sources
    op(I_PUSHQ, 64'hDEADBEEFCAFEF00D, 64'h3F8, 64'h0, 1'b0, lat, vm, er);
    op(I_POPQ, 64'h3F8, 64'h10, 64'h0, 1'b0, lat, vm, er);
    chk("pop_valM", vm, 64'hDEADBEEFCAFEF00D);
    op(I_CALL, 64'h10, 64'h3F0, 64'h40, 1'b0, lat, vm, er);
    op(I_RET, 64'h3F0, 64'h10, 64'h0, 1'b0, lat, vm, er);
    chk("ret_valM", vm, 64'h40);

    // range boundary
    op(I_MRMOVQ, 64'h0, 64'h3F8, 64'h0, 1'b0, lat, vm, er);
    chk("edge_err", {63'd0, er}, 64'd0);
    chk("edge_valM", vm, 64'hDEADBEEFCAFEF00D);
    op(I_MRMOVQ, 64'h0, 64'h3F9, 64'h0, 1'b0, lat, vm, er);
    chk("oor_err", {63'd0, er}, 64'd1);
    chk("oor_lat", 64'(lat), 64'(NOP_LAT));
    chk("oor_valM", vm, 64'hDEADBEEFCAFEF00D);
    chk("oor_hold", {63'd0, bus.dmem_error}, 64'd1);
    op(I_RMMOVQ, 64'h5555, 64'hFFFFFFFFFFFFFFFC, 64'h0, 1'b0, lat, vm, er);
    chk("wrap_err", {63'd0, er}, 64'd1);
    chk("wrap_lat", 64'(lat), 64'(NOP_LAT));

    // non-memory icode
    op(I_OPQ, 64'h10, 64'h10, 64'h0, 1'b0, lat, vm, er);
    chk("nop_lat", 64'(lat), 64'(NOP_LAT));
    chk("nop_err", {63'd0, er}, 64'd0);
    chk("nop_valM", vm, 64'hDEADBEEFCAFEF00D);
    op(I_MRMOVQ, 64'h0, 64'h10, 64'h0, 1'b0, lat, vm, er);
    chk("nop_mem", vm, 64'h1122334455667788);

    // start held through a store: inputs change mid-op, latched copy is used
    op(I_RMMOVQ, 64'h0123456789ABCDEF, 64'h30, 64'h0, 1'b1, lat, vm, er);
    chk("hold_lat", 64'(lat), 64'(MEM_LAT));
    chk("hold_busy", {63'd0, bus.busy}, 64'd0);
    op(I_MRMOVQ, 64'h0, 64'h30, 64'h0, 1'b0, lat, vm, er);
    chk("hold_data", vm, 64'h0123456789ABCDEF);

    // start held across DONE is ignored, then accepted in the following IDLE
    @(negedge clk);
    bus.icode = I_OPQ; bus.start = 1'b1;
    @(posedge clk); #1;
    chk("hs_done1", {63'd0, bus.done}, 64'd1);
    @(posedge clk); #1;
    chk("hs_idle", {62'd0, bus.busy, bus.done}, 64'd0);
    @(posedge clk); #1;
    chk("hs_done2", {62'd0, bus.busy, bus.done}, 64'd3);
    bus.start = 1'b0;
    @(posedge clk); #1;

    // reset after beat 3 of a store over a zeroed word
    op(I_RMMOVQ, 64'h0, 64'h20, 64'h0, 1'b0, lat, vm, er);
    @(negedge clk);
    bus.icode = I_RMMOVQ; bus.valA = 64'hAAAAAAAAAAAAAAAA; bus.valE = 64'h20; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("mid_busy", {63'd0, bus.busy}, 64'd0);
    chk("mid_valM", bus.valM, 64'd0);
    @(negedge clk); rst = 1'b0;
    op(I_MRMOVQ, 64'h0, 64'h20, 64'h0, 1'b0, lat, vm, er);
    chk("mid_mem", vm, 64'h00000000AAAAAAAA);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
